// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: pulse/ready ram-style port shared by requesters and the ram
interface ram_arbiter_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int WORD_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [WORD_WIDTH-1:0] din;
  logic [WORD_WIDTH-1:0] dout;
  logic                  re;
  logic                  we;
  logic                  ready;
  modport master (output addr, din, re, we, input dout, ready);
  modport slave  (input addr, din, re, we, output dout, ready);
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter sharing one single-port ram between two requesters
module ram_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int WORD_WIDTH = 64
) (
  input logic           clk,
  input logic           rst,
  ram_arbiter_if.slave  p0,
  ram_arbiter_if.slave  p1,
  ram_arbiter_if.master m
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t                r_state, w_next;
  logic [1:0]            r_pend, r_rd, w_re, w_req, w_idle, w_cap;
  logic [ADDR_WIDTH-1:0] r_addr [2];
  logic [ADDR_WIDTH-1:0] w_addr [2];
  logic [WORD_WIDTH-1:0] r_din [2];
  logic [WORD_WIDTH-1:0] w_din [2];
  logic [WORD_WIDTH-1:0] r_dout [2];
  logic [ADDR_WIDTH-1:0] r_m_addr;
  logic [WORD_WIDTH-1:0] r_m_din;
  logic                  r_m_re, r_m_we, r_grant, r_last, w_pick;
  assign w_re    = {p1.re, p0.re};
  assign w_req   = {p1.re | p1.we, p0.re | p0.we};
  assign w_addr[0] = p0.addr;
  assign w_addr[1] = p1.addr;
  assign w_din[0]  = p0.din;
  assign w_din[1]  = p1.din;
  // capture uses idle rather than ready, since ready already masks the request strobes
  assign w_idle[0] = !r_pend[0] && !(r_state != IDLE && !r_grant);
  assign w_idle[1] = !r_pend[1] && !(r_state != IDLE && r_grant);
  assign w_cap     = w_idle & w_req;
  assign p0.ready  = w_idle[0] && !w_req[0];
  assign p1.ready  = w_idle[1] && !w_req[1];
  assign p0.dout   = r_dout[0];
  assign p1.dout   = r_dout[1];
  assign m.addr    = r_m_addr;
  assign m.din     = r_m_din;
  assign m.re      = r_m_re;
  assign m.we      = r_m_we;
  assign w_pick    = &r_pend ? !r_last : r_pend[1];
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE  ? (|r_pend ? ISSUE : IDLE) :
             r_state == ISSUE ? WAIT :
             m.ready          ? IDLE : WAIT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_pend   <= '0;
      r_rd     <= '0;
      r_grant  <= 1'b0;
      r_last   <= 1'b1;
      r_m_addr <= '0;
      r_m_din  <= '0;
      r_m_re   <= 1'b0;
      r_m_we   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_addr[i] <= '0;
        r_din[i]  <= '0;
        r_dout[i] <= '0;
      end
    end else begin
      r_state <= w_next;
      for (int i = 0; i < 2; i++) begin
        if (w_cap[i]) begin
          r_pend[i] <= 1'b1;
          r_rd[i]   <= w_re[i];
          r_addr[i] <= w_addr[i];
          r_din[i]  <= w_din[i];
        end
      end
      if (r_state == IDLE && |r_pend) begin
        r_grant  <= w_pick;
        r_m_addr <= r_addr[w_pick];
        r_m_din  <= r_din[w_pick];
        r_m_re   <= r_rd[w_pick];
        r_m_we   <= !r_rd[w_pick];
      end
      if (r_state == ISSUE) begin
        r_m_re <= 1'b0;
        r_m_we <= 1'b0;
      end
      if (r_state == WAIT && m.ready) begin
        if (r_rd[r_grant]) r_dout[r_grant] <= m.dout;
        r_pend[r_grant] <= 1'b0;
        r_last          <= r_grant;
      end
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter against a latency-10 ram model
module tb_ram_arbiter;
  localparam int L = 10;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int n_strobe = 0;
  int n_we = 0;
  int d0 = 0;
  int d1 = 0;
  int q_cyc [$];
  logic [63:0] q_addr [$];
  logic [63:0] mem [logic [63:0]];
  int r_cnt;
  logic r_rd;
  logic [63:0] r_ra;
  ram_arbiter_if #(.ADDR_WIDTH(64), .WORD_WIDTH(64)) p0_if ();
  ram_arbiter_if #(.ADDR_WIDTH(64), .WORD_WIDTH(64)) p1_if ();
  ram_arbiter_if #(.ADDR_WIDTH(64), .WORD_WIDTH(64)) m_if ();
  ram_arbiter #(.ADDR_WIDTH(64), .WORD_WIDTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .p0  (p0_if),
    .p1  (p1_if),
    .m   (m_if)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : '1;
  endfunction
  // ram: samples a strobe, stays busy, raises ready with data L-1 edges later
  always @(posedge clk) begin
    if (rst) begin
      m_if.ready <= 1'b1;
      m_if.dout  <= '0;
      r_cnt      <= 0;
    end else if (r_cnt != 0) begin
      r_cnt <= r_cnt - 1;
      if (r_cnt == 1) begin
        m_if.ready <= 1'b1;
        if (r_rd) m_if.dout <= mem_rd(r_ra);
      end
    end else if (m_if.re || m_if.we) begin
      m_if.ready <= 1'b0;
      r_cnt      <= L - 1;
      r_rd       <= m_if.re;
      r_ra       <= m_if.addr;
      if (!m_if.re) mem[m_if.addr] = m_if.din;
    end
  end
  always @(negedge clk) begin
    if (m_if.re || m_if.we) begin
      n_strobe++;
      n_we += m_if.we ? 1 : 0;
      q_cyc.push_back(cyc);
      q_addr.push_back(m_if.addr);
    end
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic req(input bit port, input logic re, input logic we, input logic [63:0] a,
                     input logic [63:0] d, output int c);
    @(negedge clk);
    if (port) begin
      p1_if.re = re; p1_if.we = we; p1_if.addr = a; p1_if.din = d;
    end else begin
      p0_if.re = re; p0_if.we = we; p0_if.addr = a; p0_if.din = d;
    end
    @(posedge clk);
    #1;
    c = cyc;
    if (port) begin
      p1_if.re = 1'b0; p1_if.we = 1'b0;
    end else begin
      p0_if.re = 1'b0; p0_if.we = 1'b0;
    end
  endtask
  task automatic wait_ready(input bit port, output int n);
    n = 0;
    @(negedge clk);
    while (!(port ? p1_if.ready : p0_if.ready) && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) check(port ? "p1_ready_timeout" : "p0_ready_timeout",
                        port ? p1_if.ready : p0_if.ready, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, expected finish before 200000");
    $fatal(1, "bench timeout");
  end
  initial begin
    int c, n, c_done, s0, w0, fc0, fn0, fc1, fn1;
    p0_if.re = 1'b0; p0_if.we = 1'b0; p0_if.addr = '0; p0_if.din = '0;
    p1_if.re = 1'b0; p1_if.we = 1'b0; p1_if.addr = '0; p1_if.din = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_re", m_if.re, 0);
    check("rst_m_we", m_if.we, 0);
    check("rst_m_addr", m_if.addr, 0);
    check("rst_m_din", m_if.din, 0);
    check("rst_p0_dout", p0_if.dout, 0);
    check("rst_p1_dout", p1_if.dout, 0);
    check("rst_p0_ready", p0_if.ready, 1);
    check("rst_p1_ready", p1_if.ready, 1);
    rst = 1'b0;
    req(0, 1'b0, 1'b1, 64'd5, 64'hA5, c);
    wait_ready(0, n);
    check("wr_ready_low", n, 12);
    check("wr_strobe_cyc", q_cyc[0] - c, 1);
    check("wr_addr", q_addr[0], 5);
    check("wr_we_count", n_we, 1);
    check("wr_mem5", mem_rd(5), 64'hA5);
    req(0, 1'b1, 1'b0, 64'd5, 64'h0, c);
    wait_ready(0, n);
    check("rd_ready_low", n, 12);
    check("rd_dout", p0_if.dout, 64'hA5);
    check("rd_strobes", n_strobe, 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q_cyc.delete();
    q_addr.delete();
    @(negedge clk);
    p0_if.re = 1'b1; p0_if.addr = 64'd5;
    p1_if.re = 1'b1; p1_if.addr = 64'd6;
    @(posedge clk);
    #1;
    p0_if.re = 1'b0;
    p1_if.re = 1'b0;
    wait_ready(0, n);
    c_done = cyc;
    wait_ready(1, n);
    check("sim_first", q_addr[0], 5);
    check("sim_second", q_addr[1], 6);
    check("sim_gap", q_cyc[1] - c_done, 1);
    check("sim_p0_dout", p0_if.dout, 64'hA5);
    check("sim_p1_dout", p1_if.dout, '1);
    q_cyc.delete();
    q_addr.delete();
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          req(0, 1'b1, 1'b0, 64'(100 + i), 64'h0, fc0);
          wait_ready(0, fn0);
          d0 += p0_if.ready ? 1 : 0;
        end
      end
      begin
        for (int j = 0; j < 8; j++) begin
          req(1, 1'b1, 1'b0, 64'(200 + j), 64'h0, fc1);
          wait_ready(1, fn1);
          d1 += p1_if.ready ? 1 : 0;
        end
      end
    join
    check("fair_done0", d0, 8);
    check("fair_done1", d1, 8);
    check("fair_strobes", q_addr.size(), 16);
    for (int k = 0; k < 16; k++)
      check($sformatf("fair_grant%0d", k), q_addr[k], 64'((k % 2 == 1 ? 200 : 100) + k / 2));
    w0 = n_we;
    req(1, 1'b1, 1'b1, 64'd7, 64'h1234, c);
    wait_ready(1, n);
    check("prio_dout", p1_if.dout, '1);
    check("prio_no_write", n_we, w0);
    check("prio_mem7", mem_rd(7), '1);
    check("prio_addr", q_addr[$], 7);
    s0 = n_strobe;
    req(0, 1'b1, 1'b0, 64'd5, 64'h0, c);
    req(0, 1'b1, 1'b0, 64'd6, 64'h0, c);
    wait_ready(0, n);
    repeat (20) @(negedge clk);
    check("drop_strobes", n_strobe - s0, 1);
    check("drop_addr", q_addr[$], 5);
    check("drop_dout", p0_if.dout, 64'hA5);
    req(0, 1'b1, 1'b0, 64'd5, 64'h0, c);
    req(1, 1'b1, 1'b0, 64'd6, 64'h0, c);
    repeat (3) @(negedge clk);
    check("mid_p1_pending", p1_if.ready, 0);
    check("mid_ram_busy", m_if.ready, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid_m_re", m_if.re, 0);
    check("mid_m_we", m_if.we, 0);
    check("mid_p0_ready", p0_if.ready, 1);
    check("mid_p1_ready", p1_if.ready, 1);
    s0 = n_strobe;
    repeat (30) @(negedge clk);
    check("mid_no_strobe", n_strobe, s0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
